seq_divider: RTL

Sequential unsigned restoring divider: dividend `A` and divisor `B`, one quotient bit per clock, with a start/busy/done handshake. It inverts the team's ripple-carry adder by repeated trial subtraction. It sits beside the adder in the arithmetic datapath and serves control logic that can tolerate multi-cycle latency in exchange for a small, ripple-only datapath.

---
 rtl/arith_pkg.sv | 22 ++
 rtl/seq_divider_subtractor.sv | 17 +
 rtl/seq_divider.sv | 126 ++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   state_t       : divider control states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH : default operand width
//   DEFAULT_CNT_W : iteration-counter width for DEFAULT_WIDTH
//   cnt_width()   : iteration-counter width for an arbitrary operand width
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    // The counter must hold values WIDTH down to 1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_subtractor.sv
// One-bit full subtractor, the cell of the divider's trial-subtraction chain.
//   A, B  : minuend and subtrahend bits
//   b_in  : borrow from the less significant stage
//   b_out : borrow to the more significant stage
//   diff  : difference bit
module Subtractor (
    input  logic A,
    input  logic B,
    input  logic b_in,
    output logic b_out,
    output logic diff
);

    assign diff  = A ^ B ^ b_in;
    assign b_out = (~A & B) | (~A & b_in) | (B & b_in);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   start             : request a division (honoured in IDLE or DONE only)
//   A, B              : dividend and divisor, captured on the accepting edge
//   busy              : division in progress
//   done              : one-cycle pulse, results valid from this cycle on
//   quotient          : result, held until the next accepted start
//   remainder         : result, held until the next accepted start
//   div_by_zero       : captured divisor was zero (quotient all ones,
//                       remainder = dividend)
module seq_divider
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] v_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   v_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;
    logic             restore;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The partial remainder is always below the divisor after each step, so
    // its top bit is permanently zero and only WIDTH bits are stored; the
    // trial subtraction still runs over the full WIDTH+1-bit shifted value.
    assign r_shift   = {r_reg, d_reg[WIDTH-1]};
    assign v_ext     = {1'b0, v_reg};
    assign borrow[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
        Subtractor u_sub (
            .A     (r_shift[i]),
            .B     (v_ext[i]),
            .b_in  (borrow[i]),
            .b_out (borrow[i+1]),
            .diff  (diff[i])
        );
    end

    // Without a final borrow the difference is below the divisor, so its MSB
    // is zero; OR-ing it in leaves the restore decision unchanged.
    assign restore = borrow[WIDTH+1] | diff[WIDTH];
    assign r_next  = restore ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next  = {q_reg[WIDTH-2:0], ~restore};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            d_reg       <= '0;
            v_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        d_reg       <= A;
                        v_reg       <= B;
                        r_reg       <= '0;
                        q_reg       <= '0;
                        cnt         <= CW'(WIDTH);
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        if (B == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    d_reg <= {d_reg[WIDTH-2:0], 1'b0};
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
